sc_mem_arbiter: RTL
===================

SC_MEM_ARBITER -- requirements
Module: sc_mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requesters and the memory port.
REQ-002 Parameter: DW, 32, data width of both requesters and the memory port.
REQ-003 clock  input  1  single clock, rising-edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 c_req, c_we  input  1 each  CPU requester: request, write-enable.
REQ-006 c_addr  input  AW  CPU address; c_wdata  input  DW  CPU write data.
REQ-007 c_rdata  output  DW  CPU read data; c_ack  output  1  CPU completion pulse.
REQ-008 d_req, d_we  input  1 each  debug/loader requester: request, write-enable.
REQ-009 d_addr  input  AW  debug address; d_wdata  input  DW  debug write data.
REQ-010 d_rdata  output  DW  debug read data; d_ack  output  1  debug completion pulse.
REQ-011 m_en, m_we  output  1 each  data-memory enable, write-enable.
REQ-012 m_addr  output  AW; m_wdata  output  DW  memory address and write data.
REQ-013 m_rdata  input  DW  memory read data, valid the cycle after m_en.
REQ-014 busy  output  1  transaction in progress; owner  output  1  current/last grantee (0=CPU, 1=debug).

Function
REQ-015 FSM states: IDLE, ISSUE, RESP, ACK; all outputs registered.
REQ-016 IDLE: any x_req sampled high on a clock edge -> winner latched, m_addr/m_wdata/m_we loaded from winner, m_en=1, state ISSUE.
REQ-017 ISSUE: m_en high exactly one cycle; next state RESP; m_en, m_we cleared.
REQ-018 RESP: m_rdata captured into winner's x_rdata at the closing edge; next state ACK.
REQ-019 ACK: winner's x_ack high exactly one cycle; loser's ack stays 0; next state IDLE.
REQ-020 Latency: req sampled at edge k -> m_en high cycle k+1 -> x_ack high cycle k+3; one transaction per 4 cycles maximum.
REQ-021 Requester holds req, we, addr, wdata stable until ack; arbiter ignores input changes outside IDLE.
REQ-022 Requester drops req the cycle after ack unless issuing a new request; req high in IDLE always counts as a new request.
REQ-023 Writes: x_rdata still updated with m_rdata in RESP (value unspecified); ack timing identical to reads.
REQ-024 Non-winner's x_rdata holds its previous value.
REQ-025 busy high in ISSUE, RESP and ACK; low in IDLE.
REQ-026 owner updates only on grant in IDLE; holds otherwise.
REQ-027 Single request pending: granted immediately regardless of priority mode.

Reset
REQ-028 resetn low asynchronously forces: state IDLE, m_en=0, m_we=0, m_addr=0, m_wdata=0, c_ack=0, d_ack=0, c_rdata=0, d_rdata=0, busy=0, owner=1.
REQ-029 Reset mid-transaction abandons it; no ack issued for it after reset release.
REQ-030 First arbitration edge after resetn rises may grant.

Configuration
REQ-031 Macro SC_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE granted to requester != owner (alternating); reset owner=1 makes CPU win first.
REQ-032 Macro SC_ARB_ROUND_ROBIN_EN undefined: simultaneous requests always grant CPU (fixed priority); debug served only when c_req low in IDLE.

Verification
REQ-033 CPU read: c_req=1, c_addr=0x10, m_rdata=0xDEADBEEF in RESP -> m_en cycle 1, c_ack cycle 3, c_rdata=0xDEADBEEF, d_ack never high.
REQ-034 Debug write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> m_en=1, m_we=1, m_addr=0x20, m_wdata=0x12345678 one cycle, d_ack cycle 3, owner=1.
REQ-035 Both held high continuously, 4 transactions, macro defined -> grant order CPU, debug, CPU, debug; macro undefined -> CPU x4, no d_ack.
REQ-036 Reset during RESP of CPU read -> all outputs zero, owner=1, no c_ack; re-request after release completes with c_ack 3 cycles after grant edge.
REQ-037 Input change during ISSUE: c_addr changed 0x10->0x44 -> m_addr stays 0x10 until ACK; busy=1 in ISSUE/RESP/ACK, 0 in IDLE.

Source files
------------

// File: rtl/sc_mem_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single-cycle data memory port.
// Fixed CPU priority by default; define SC_ARB_ROUND_ROBIN_EN for alternating grants.
module sc_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state, state_nx;
  req_t          c_r, d_r, win;
  logic          grant;
  logic          m_en_nx, m_we_nx, c_ack_nx, d_ack_nx, busy_nx, owner_nx;
  logic [AW-1:0] m_addr_nx;
  logic [DW-1:0] m_wdata_nx, c_rdata_nx, d_rdata_nx;

  assign c_r = {c_we, c_addr, c_wdata};
  assign d_r = {d_we, d_addr, d_wdata};

  // grant: 0 = CPU, 1 = debug; a lone requester always wins
`ifdef SC_ARB_ROUND_ROBIN_EN
  assign grant = (c_req && d_req) ? ~owner : ~c_req;
`else
  assign grant = ~c_req;
`endif

  assign win = grant ? d_r : c_r;

  always_comb begin
    state_nx   = state;
    m_en_nx    = 1'b0;
    m_we_nx    = 1'b0;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    c_ack_nx   = 1'b0;
    d_ack_nx   = 1'b0;
    c_rdata_nx = c_rdata;
    d_rdata_nx = d_rdata;
    busy_nx    = busy;
    owner_nx   = owner;
    case (state)
      IDLE: if (c_req || d_req) begin
        state_nx   = ISSUE;
        owner_nx   = grant;
        m_en_nx    = 1'b1;
        m_we_nx    = win.we;
        m_addr_nx  = win.addr;
        m_wdata_nx = win.wdata;
        busy_nx    = 1'b1;
      end
      ISSUE: state_nx = RESP;
      // owner already names the current winner here
      RESP: begin
        state_nx = ACK;
        if (owner) begin
          d_rdata_nx = m_rdata;
          d_ack_nx   = 1'b1;
        end else begin
          c_rdata_nx = m_rdata;
          c_ack_nx   = 1'b1;
        end
      end
      ACK: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      c_ack   <= 1'b0;
      d_ack   <= 1'b0;
      c_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
      owner   <= 1'b1;
    end else begin
      state   <= state_nx;
      m_en    <= m_en_nx;
      m_we    <= m_we_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      c_ack   <= c_ack_nx;
      d_ack   <= d_ack_nx;
      c_rdata <= c_rdata_nx;
      d_rdata <= d_rdata_nx;
      busy    <= busy_nx;
      owner   <= owner_nx;
    end
  end

endmodule
